// File: rtl/rv_pkg.sv
// Shared definitions for the register-file read side.
// Provides register-index width, register count, default datapath width
// and the register-index type used by operand_fetch_stage and rv_scoreboard.
package rv_pkg;
  localparam int REG_AW       = 5;
  localparam int NREG         = 32;
  localparam int XLEN_DEFAULT = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/rv_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_set_en / i_set_idx   mark a register as having a writer in flight
//   i_clr_en / i_clr_idx   writeback retires a register (caller excludes x0)
//   i_sq_en  / i_sq_idx    squash of a flushed, never-transferred writer
//   i_q_rs1 / i_q_rs2      source indices to check
//   i_q_rd / i_q_rd_chk    destination index to check (WAW) and its enable
//   o_hazard               combinational stall request
//   o_busy                 current busy vector
module rv_scoreboard
  import rv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_set_en,
  input  reg_idx_t        i_set_idx,
  input  logic            i_clr_en,
  input  reg_idx_t        i_clr_idx,
  input  logic            i_sq_en,
  input  reg_idx_t        i_sq_idx,
  input  reg_idx_t        i_q_rs1,
  input  reg_idx_t        i_q_rs2,
  input  reg_idx_t        i_q_rd,
  input  logic            i_q_rd_chk,
  output logic            o_hazard,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_hit3;

  // A writeback in the same cycle is bypassed, so it cancels the stall.
  assign w_hit1 = i_clr_en && (i_clr_idx == i_q_rs1);
  assign w_hit2 = i_clr_en && (i_clr_idx == i_q_rs2);
  assign w_hit3 = i_clr_en && (i_clr_idx == i_q_rd);

  assign o_hazard = (r_busy[i_q_rs1] && !w_hit1) ||
                    (r_busy[i_q_rs2] && !w_hit2) ||
                    (i_q_rd_chk && r_busy[i_q_rd] && !w_hit3);

  // Set is applied last so a same-index set and clear resolves to set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_sq_en)  w_busy_nxt[i_sq_idx]  = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: drives register-file read addresses, bypasses same-cycle
// writeback data, stalls on RAW/WAW hazards via rv_scoreboard and presents
// results through a one-entry valid/ready output register.
// Ports:
//   CLK, RST                         clock, asynchronous active-high reset
//   in_valid/in_ready, in_rs1/2, in_rd, in_rd_we, in_ctrl   decoded input
//   rf_a1/rf_a2, rf_rd1/rf_rd2       combinational register-file read
//   wb_we, wb_a, wb_wd               writeback port (bypass + scoreboard clear)
//   flush                            squash a held, non-transferring output
//   out_valid/out_ready, out_*       registered result to execute
module operand_fetch_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_idx_t          in_rs1,
  input  reg_idx_t          in_rs2,
  input  reg_idx_t          in_rd,
  input  logic              in_rd_we,
  input  logic [CTRL_W-1:0] in_ctrl,
  output reg_idx_t          rf_a1,
  output reg_idx_t          rf_a2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  reg_idx_t          wb_a,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output reg_idx_t          out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_rs1_val;
  logic [XLEN-1:0]   r_out_rs2_val;
  reg_idx_t          r_out_rd;
  logic              r_out_rd_we;
  logic [CTRL_W-1:0] r_out_ctrl;

  logic              w_wb_clr;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_set_en;
  logic              w_squash;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [NREG-1:0]   w_busy;

  // x0 reads as zero; otherwise a same-cycle writeback wins over the RF.
  function automatic logic [XLEN-1:0] sel_operand(
    input reg_idx_t        rs,
    input logic [XLEN-1:0] rf_val,
    input logic            wb_clr,
    input reg_idx_t        wa,
    input logic [XLEN-1:0] wd
  );
    if (rs == '0)                    return '0;
    else if (wb_clr && (wa == rs))   return wd;
    else                             return rf_val;
  endfunction

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  // Writes to x0 are ignored everywhere, including the bypass.
  assign w_wb_clr   = wb_we && (wb_a != '0);
  assign w_in_ready = !w_hazard && !flush && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_set_en   = w_accept && in_rd_we && (in_rd != '0);
  // Only a held (non-transferring) instruction gives back its busy bit.
  assign w_squash   = flush && r_out_valid && !out_ready && r_out_rd_we;

  assign w_op1 = sel_operand(in_rs1, rf_rd1, w_wb_clr, wb_a, wb_wd);
  assign w_op2 = sel_operand(in_rs2, rf_rd2, w_wb_clr, wb_a, wb_wd);

  rv_scoreboard u_sb (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_set_en   (w_set_en),
    .i_set_idx  (in_rd),
    .i_clr_en   (w_wb_clr),
    .i_clr_idx  (wb_a),
    .i_sq_en    (w_squash),
    .i_sq_idx   (r_out_rd),
    .i_q_rs1    (in_rs1),
    .i_q_rs2    (in_rs2),
    .i_q_rd     (in_rd),
    .i_q_rd_chk (in_rd_we),
    .o_hazard   (w_hazard),
    .o_busy     (w_busy)
  );

  // Output register: load on accept, drain on transfer or flush, else hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_valid   <= 1'b0;
      r_out_rs1_val <= '0;
      r_out_rs2_val <= '0;
      r_out_rd      <= '0;
      r_out_rd_we   <= 1'b0;
      r_out_ctrl    <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_rs1_val <= w_op1;
      r_out_rs2_val <= w_op2;
      r_out_rd      <= in_rd;
      r_out_rd_we   <= in_rd_we;
      r_out_ctrl    <= in_ctrl;
    end else if (out_ready || flush) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_rs1_val = r_out_rs1_val;
  assign out_rs2_val = r_out_rs2_val;
  assign out_rd      = r_out_rd;
  assign out_rd_we   = r_out_rd_we;
  assign out_ctrl    = r_out_ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  import rv_pkg::*;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  logic              CLK;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  reg_idx_t          in_rs1, in_rs2, in_rd;
  logic              in_rd_we;
  logic [CTRL_W-1:0] in_ctrl;
  reg_idx_t          rf_a1, rf_a2;
  logic [XLEN-1:0]   rf_rd1, rf_rd2;
  logic              wb_we;
  reg_idx_t          wb_a;
  logic [XLEN-1:0]   wb_wd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_val, out_rs2_val;
  reg_idx_t          out_rd;
  logic              out_rd_we;
  logic [CTRL_W-1:0] out_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_ctrl(in_ctrl),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_a(wb_a), .wb_wd(wb_wd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input reg_idx_t r1, input reg_idx_t r2,
                       input reg_idx_t rd, input logic we, input logic [CTRL_W-1:0] c);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_we = we; in_ctrl = c;
  endtask

  task automatic wb(input logic we, input reg_idx_t a, input logic [XLEN-1:0] d);
    wb_we = we; wb_a = a; wb_wd = d;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; out_ready = 1'b1;
    rf_rd1 = '0; rf_rd2 = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
    wb(1'b0, 5'd0, 32'h0);
    step(); step();
    RST = 1'b0;
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_busy", dut.u_sb.r_busy, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rf_a1_comb", {27'b0, rf_a1}, 32'h0);

    // Basic issue
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 16'hA5A5);
    rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    #1;
    chk("rf_a1", {27'b0, rf_a1}, 32'd1);
    chk("rf_a2", {27'b0, rf_a2}, 32'd2);
    chk("issue_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("issue_out_valid", {31'b0, out_valid}, 32'h1);
    chk("issue_rs1_val", out_rs1_val, 32'h11);
    chk("issue_rs2_val", out_rs2_val, 32'h22);
    chk("issue_rd", {27'b0, out_rd}, 32'd3);
    chk("issue_rd_we", {31'b0, out_rd_we}, 32'h1);
    chk("issue_ctrl", {16'b0, out_ctrl}, 32'hA5A5);
    chk("issue_busy", dut.u_sb.r_busy, 32'h0000_0008);
    step();
    chk("drain_out_valid", {31'b0, out_valid}, 32'h0);

    // RAW stall resolved by same-cycle writeback bypass
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 16'h0001);
    step();
    in_valid = 1'b0;
    chk("set5_busy", dut.u_sb.r_busy, 32'h0000_0028);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 16'h0002);
    rf_rd1 = 32'h55;
    #1;
    chk("raw_stall_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    chk("raw_stall_no_load", {31'b0, out_valid}, 32'h0);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("raw_bypass_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0; wb(1'b0, 5'd0, 32'h0);
    chk("raw_bypass_val", out_rs1_val, 32'hDEADBEEF);
    chk("raw_rs2_zero", out_rs2_val, 32'h0);
    chk("raw_busy", dut.u_sb.r_busy, 32'h0000_0008);

    // x0 source and destination, writeback to x0 ignored
    drive(1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 16'h0003);
    rf_rd1 = 32'hFFFFFFFF; rf_rd2 = 32'h44;
    wb(1'b1, 5'd0, 32'h12345678);
    step();
    in_valid = 1'b0; wb(1'b0, 5'd0, 32'h0);
    chk("x0_rs1_val", out_rs1_val, 32'h0);
    chk("x0_rs2_val", out_rs2_val, 32'h44);
    chk("x0_busy", dut.u_sb.r_busy, 32'h0000_0008);

    // WAW stall, then set and clear of the same index in one cycle
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 16'h0004);
    #1;
    chk("waw_stall", {31'b0, in_ready}, 32'h0);
    wb(1'b1, 5'd3, 32'h33);
    #1;
    chk("waw_release", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("set_wins_busy", dut.u_sb.r_busy, 32'h0000_0008);
    chk("waw_out_rd", {27'b0, out_rd}, 32'd3);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("wb_clear_busy", dut.u_sb.r_busy, 32'h0);
    chk("wb_out_valid", {31'b0, out_valid}, 32'h0);

    // Backpressure hold for three cycles
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 16'h1234);
    rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    step();
    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 16'h5555);
    rf_rd1 = 32'h88; rf_rd2 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      step();
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_rs1", out_rs1_val, 32'h11);
      chk("bp_rs2", out_rs2_val, 32'h22);
      chk("bp_rd", {27'b0, out_rd}, 32'd7);
      chk("bp_ctrl", {16'b0, out_ctrl}, 32'h1234);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_next_rs1", out_rs1_val, 32'h88);
    chk("bp_next_rs2", out_rs2_val, 32'h99);
    chk("bp_next_rd", {27'b0, out_rd}, 32'd10);
    chk("bp_next_ctrl", {16'b0, out_ctrl}, 32'h5555);
    chk("bp_busy", dut.u_sb.r_busy, 32'h0000_0480);
    wb(1'b1, 5'd7, 32'h0);
    step();
    wb(1'b1, 5'd10, 32'h0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("bp_clear_busy", dut.u_sb.r_busy, 32'h0);

    // Flush of a held instruction returns its busy bit
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 16'h0007);
    rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    step();
    in_valid = 1'b0;
    chk("fl_held_valid", {31'b0, out_valid}, 32'h1);
    chk("fl_held_busy", dut.u_sb.r_busy, 32'h0000_0080);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    flush = 1'b0;
    chk("fl_out_valid", {31'b0, out_valid}, 32'h0);
    chk("fl_busy", dut.u_sb.r_busy, 32'h0);
    drive(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 16'h0009);
    rf_rd1 = 32'h77;
    out_ready = 1'b1;
    #1;
    chk("fl_no_stall", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("fl_next_valid", {31'b0, out_valid}, 32'h1);
    chk("fl_next_rs1", out_rs1_val, 32'h77);
    chk("fl_next_busy", dut.u_sb.r_busy, 32'h0000_0200);

    // Flush while transferring: only in_ready is forced low
    flush = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 16'h000A);
    #1;
    chk("flx_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flx_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flx_busy_kept", dut.u_sb.r_busy, 32'h0000_0200);

    // Asynchronous reset mid-cycle with a valid output held
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 16'h00BB);
    step();
    in_valid = 1'b0;
    chk("rst_pre_valid", {31'b0, out_valid}, 32'h1);
    #3;
    RST = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_async_busy", dut.u_sb.r_busy, 32'h0);
    chk("rst_async_rd", {27'b0, out_rd}, 32'h0);
    chk("rst_async_ctrl", {16'b0, out_ctrl}, 32'h0);
    RST = 1'b0;
    #1;
    chk("rst_post_in_ready", {31'b0, in_ready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
